adc_sample_averager: RTL and testbench

Block-averaging stage placed directly downstream of the ADC serial interface. It captures each 8-bit conversion on the rising edge of the interface's `RX_DONE` and accumulates 2^LOG2_N samples. It then emits their mean on a valid/ready output port for the rest of the sys_clk-domain logic. It tracks dropped results and counts emitted blocks.

---
 rtl/adc_sample_averager.sv | 110 +++++++++++
 tb/tb_adc_sample_averager.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/adc_sample_averager.sv
// Block averager behind the ADC serial interface: sums 2^LOG2_N samples, emits the mean on valid/ready.
// Optional build macro ADC_AVG_ROUND_EN selects round-half-up instead of truncation.

// state  | meaning
// S_IDLE | disabled; accumulator, counter and overrun cleared
// S_ACC  | accumulating sample events into the current block
// S_EMIT | block complete; offer the mean to the output slot
module adc_sample_averager #(
  parameter int LOG2_N = 4
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] DATA_IN,
  input  logic       RX_DONE,
  output logic [7:0] AVG_OUT,
  output logic       AVG_VALID,
  input  logic       AVG_READY,
  output logic       OVERRUN,
  output logic [7:0] BLK_CNT
);

  localparam int N  = 1 << LOG2_N;
  localparam int CW = (LOG2_N == 0) ? 1 : LOG2_N;
  localparam int AW = 8 + LOG2_N;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  logic [1:0]    state;
  logic          rx_q;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [7:0]    result;
  logic          sample_ev;
  logic          slot_free;

  // A held-high RX_DONE yields a single event.
  assign sample_ev = RX_DONE & ~rx_q & en;
  assign slot_free = ~AVG_VALID | AVG_READY;

`ifdef ADC_AVG_ROUND_EN
  localparam logic [AW:0] RND = (AW+1)'((2 ** LOG2_N) / 2);
  logic [AW:0] acc_rnd;
  assign acc_rnd = {1'b0, acc} + RND;
  assign result  = 8'(acc_rnd >> LOG2_N);
`else
  assign result = 8'(acc >> LOG2_N);
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rx_q      <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      AVG_OUT   <= 8'd0;
      AVG_VALID <= 1'b0;
      OVERRUN   <= 1'b0;
      BLK_CNT   <= 8'd0;
    end else begin
      rx_q <= RX_DONE;
      // Consumption may be overridden below by a reload in S_EMIT.
      if (AVG_VALID && AVG_READY) AVG_VALID <= 1'b0;

      if (!en) begin
        state   <= S_IDLE;
        acc     <= '0;
        cnt     <= '0;
        OVERRUN <= 1'b0;
      end else begin
        case (state)
          S_IDLE: state <= S_ACC;
          S_ACC: begin
            if (sample_ev) begin
              acc <= acc + AW'(DATA_IN);
              if (cnt == CNT_LAST) begin
                cnt   <= '0;
                state <= S_EMIT;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          S_EMIT: begin
            if (slot_free) begin
              AVG_OUT   <= result;
              AVG_VALID <= 1'b1;
              BLK_CNT   <= BLK_CNT + 8'd1;
            end else begin
              OVERRUN <= 1'b1;
            end
            state <= S_ACC;
            if (sample_ev) begin
              acc <= AW'(DATA_IN);
              cnt <= CW'(1);
            end else begin
              acc <= '0;
              cnt <= '0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager: one instance with LOG2_N=2, one with LOG2_N=0.
module tb_adc_sample_averager;

  logic       sys_clk;
  logic       rst_n;

  logic       en2, rx2, ready2;
  logic [7:0] din2;
  logic [7:0] out2, blk2;
  logic       valid2, ovr2;

  logic       en0, rx0, ready0;
  logic [7:0] din0;
  logic [7:0] out0, blk0;
  logic       valid0, ovr0;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef ADC_AVG_ROUND_EN
  localparam logic [7:0] EXP_T1 = 8'd26;
`else
  localparam logic [7:0] EXP_T1 = 8'd25;
`endif

  adc_sample_averager #(.LOG2_N(2)) u_dut2 (
    .sys_clk(sys_clk), .rst_n(rst_n), .en(en2), .DATA_IN(din2), .RX_DONE(rx2),
    .AVG_OUT(out2), .AVG_VALID(valid2), .AVG_READY(ready2),
    .OVERRUN(ovr2), .BLK_CNT(blk2)
  );

  adc_sample_averager #(.LOG2_N(0)) u_dut0 (
    .sys_clk(sys_clk), .rst_n(rst_n), .en(en0), .DATA_IN(din0), .RX_DONE(rx0),
    .AVG_OUT(out0), .AVG_VALID(valid0), .AVG_READY(ready0),
    .OVERRUN(ovr0), .BLK_CNT(blk0)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send2(input logic [7:0] v);
    din2 = v; rx2 = 1'b1; tick();
    rx2 = 1'b0; tick();
  endtask

  task automatic send0(input logic [7:0] v);
    din0 = v; rx0 = 1'b1; tick();
    rx0 = 1'b0; tick();
  endtask

  initial begin
    rst_n = 1'b0;
    en2 = 1'b0; rx2 = 1'b0; ready2 = 1'b0; din2 = 8'd0;
    en0 = 1'b0; rx0 = 1'b0; ready0 = 1'b0; din0 = 8'd0;
    #1;
    chk("rst_out",   32'(out2),   32'd0);
    chk("rst_valid", 32'(valid2), 32'd0);
    chk("rst_ovr",   32'(ovr2),   32'd0);
    chk("rst_blk",   32'(blk2),   32'd0);
    #20;
    rst_n = 1'b1;
    tick();

    // Basic block: 10+20+30+42 = 102
    en2 = 1'b1; ready2 = 1'b1;
    tick();
    send2(8'd10); send2(8'd20); send2(8'd30);
    din2 = 8'd42; rx2 = 1'b1; tick();
    chk("t1_valid_at_E", 32'(valid2), 32'd0);
    rx2 = 1'b0; tick();
    chk("t1_valid_E1", 32'(valid2), 32'd1);
    chk("t1_out",      32'(out2),   32'(EXP_T1));
    chk("t1_blk",      32'(blk2),   32'd1);
    tick();
    chk("t1_consumed", 32'(valid2), 32'd0);

    // Full-scale block must not wrap
    send2(8'd255); send2(8'd255); send2(8'd255); send2(8'd255);
    chk("t2_out", 32'(out2), 32'd255);
    chk("t2_blk", 32'(blk2), 32'd2);
    tick();

    // Slot full: second block dropped
    ready2 = 1'b0;
    send2(8'd4); send2(8'd4); send2(8'd4); send2(8'd4);
    chk("t3_out_a",   32'(out2),   32'd4);
    chk("t3_valid_a", 32'(valid2), 32'd1);
    chk("t3_blk_a",   32'(blk2),   32'd3);
    chk("t3_ovr_a",   32'(ovr2),   32'd0);
    send2(8'd8); send2(8'd8); send2(8'd8); send2(8'd8);
    chk("t3_ovr_b", 32'(ovr2), 32'd1);
    chk("t3_out_b", 32'(out2), 32'd4);
    chk("t3_blk_b", 32'(blk2), 32'd3);
    ready2 = 1'b1; tick(); ready2 = 1'b0;
    chk("t3_valid_drained", 32'(valid2), 32'd0);
    chk("t3_ovr_sticky",    32'(ovr2),   32'd1);
    tick();
    chk("t3_ovr_still", 32'(ovr2), 32'd1);
    en2 = 1'b0; tick();
    chk("t3_ovr_cleared", 32'(ovr2), 32'd0);
    en2 = 1'b1; ready2 = 1'b1; tick();

    // Held RX_DONE counts once; en low discards partial block
    din2 = 8'd100; rx2 = 1'b1;
    repeat (50) tick();
    rx2 = 1'b0; tick();
    chk("t4_held_blk", 32'(blk2), 32'd3);
    send2(8'd100);
    chk("t4_two_blk",   32'(blk2),   32'd3);
    chk("t4_two_valid", 32'(valid2), 32'd0);
    en2 = 1'b0; tick();
    en2 = 1'b1; tick();
    send2(8'd8); send2(8'd8); send2(8'd8); send2(8'd8);
    chk("t4_out",   32'(out2),   32'd8);
    chk("t4_valid", 32'(valid2), 32'd1);
    chk("t4_blk",   32'(blk2),   32'd4);
    tick();

    // Pass-through instance
    en0 = 1'b1; ready0 = 1'b1; tick();
    send0(8'd7);
    chk("t5_out_7",   32'(out0),   32'd7);
    chk("t5_valid_7", 32'(valid0), 32'd1);
    send0(8'd200);
    chk("t5_out_200", 32'(out0), 32'd200);
    send0(8'd13);
    chk("t5_out_13", 32'(out0), 32'd13);
    chk("t5_blk",    32'(blk0), 32'd3);

    // Asynchronous reset with a pending result and a partial block
    ready2 = 1'b0;
    send2(8'd20); send2(8'd20); send2(8'd20); send2(8'd20);
    chk("t6_pre_valid", 32'(valid2), 32'd1);
    chk("t6_pre_out",   32'(out2),   32'd20);
    send2(8'd50); send2(8'd50);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_out",   32'(out2),   32'd0);
    chk("t6_rst_valid", 32'(valid2), 32'd0);
    chk("t6_rst_blk",   32'(blk2),   32'd0);
    chk("t6_rst_ovr",   32'(ovr2),   32'd0);
    chk("t6_rst_blk0",  32'(blk0),   32'd0);
    chk("t6_rst_out0",  32'(out0),   32'd0);
    #2 rst_n = 1'b1;
    tick();
    send2(8'd12); send2(8'd12);
    chk("t6_no_early_emit", 32'(valid2), 32'd0);
    send2(8'd12); send2(8'd12);
    chk("t6_post_out", 32'(out2), 32'd12);
    chk("t6_post_blk", 32'(blk2), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
